// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// FSM encodings, Booth op codes and the recode helper.
package booth_mult_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    // {Q[0], q_m1}: 01 adds M, 10 subtracts M, else no-op
    function automatic logic [1:0] booth_op(input logic q0, input logic qm1);
        logic [1:0] op;
        op = OP_NOP;
        if (!q0 && qm1)
            op = OP_ADD;
        else if (q0 && !qm1)
            op = OP_SUB;
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_seq_sel.sv
// Booth recode: picks the adder B operand and carry-in
// from the current multiplier bit pair.
module booth_mult_seq_sel
    import booth_mult_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             q0,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin
);

    logic [1:0] op;

    always_comb begin
        op      = booth_op(q0, q_m1);
        add_b   = '0;
        add_cin = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): begin
                add_b = m;
            end
            (op == OP_SUB): begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: begin
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth signed multiplier using an external CLA.
// Optional BOOTH_MULT_ZERO_SKIP_EN finishes zero-operand products at once.
module booth_mult_seq
    import booth_mult_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             ovf,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_ovf
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] count;

    logic             s;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] q_nx;
    logic             ovf_nx;
    logic             skip;

    booth_mult_seq_sel #(
        .WIDTH(WIDTH)
    ) u_sel (
        .q0     (q[0]),
        .q_m1   (q_m1),
        .m      (m),
        .add_b  (add_b),
        .add_cin(add_cin)
    );

    assign add_a = a;

    // add_ovf restores the true sign when M is the most-negative value
    assign s      = add_sum[WIDTH-1] ^ add_ovf;
    assign a_nx   = {s, add_sum[WIDTH-1:1]};
    assign q_nx   = {add_sum[0], q[WIDTH-1:1]};
    assign ovf_nx = (a_nx != {WIDTH{q_nx[WIDTH-1]}});

`ifdef BOOTH_MULT_ZERO_SKIP_EN
    assign skip = (multiplicand == '0) || (multiplier == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            a         <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            m         <= '0;
            count     <= '0;
            result    <= '0;
            result_hi <= '0;
            ovf       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_RUN: begin
                    a     <= a_nx;
                    q     <= q_nx;
                    q_m1  <= q[0];
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= q_nx;
                        result_hi <= a_nx;
                        ovf       <= ovf_nx;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        a     <= '0;
                        q_m1  <= 1'b0;
                        count <= CNT_LOAD;
                        if (skip) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            result    <= '0;
                            result_hi <= '0;
                            ovf       <= 1'b0;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
